// File: rtl/memory_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : memory_controller_pkg
//  Brief    : Shared state encoding, default I/O addresses and helpers
//  Revision : 1.0
// ============================================================================
package memory_controller_pkg;

    localparam logic [31:0] SWITCH_BASE_ADDR = 32'h0000_F000;
    localparam logic [31:0] LED_BASE_ADDR    = 32'h0000_F004;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SRC_ADDR = 3'd1,
        ST_SRC_WAIT = 3'd2,
        ST_IND_ADDR = 3'd3,
        ST_IND_WAIT = 3'd4,
        ST_WRITE    = 3'd5,
        ST_NEXT     = 3'd6
    } seq_state_e;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_mirror_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface : io_mirror_sequencer_if
//  Brief     : Memory controller bus between sequencer (master) and memory
//  Revision  : 1.0
// ============================================================================
interface io_mirror_sequencer_if;
    logic [31:0] addr_out;
    logic [31:0] wr_data_out;
    logic [31:0] rd_data_in;
    logic        we_out;

    modport master (output addr_out, output wr_data_out, output we_out, input rd_data_in);
    modport slave  (input addr_out, input wr_data_out, input we_out, output rd_data_in);
endinterface
`default_nettype wire

// File: rtl/io_mirror_lat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : io_mirror_lat_cnt
//  Brief    : Read-latency wait counter; done_out marks the last wait cycle
//  Revision : 1.0
// ============================================================================
module io_mirror_lat_cnt #(
    parameter int RD_LATENCY = 1
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  wire logic start_in,
    output logic      done_out
);
    localparam int                c_cnt_w = $clog2(RD_LATENCY) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(RD_LATENCY - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_active;

    // Counting starts in the cycle after start_in, i.e. the first wait cycle.
    assign done_out = r_active && (r_cnt == c_last);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start_in) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (done_out) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/io_mirror_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : io_mirror_sequencer
//  Brief    : Round-robin bus master mirroring source words to destinations
//  Revision : 1.0
// ============================================================================
module io_mirror_sequencer
    import memory_controller_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  wire logic                          clk_in,
    input  wire logic                          rst_in,
    input  wire logic                          enable_in,
    input  wire logic [NUM_CH-1:0][31:0]       src_addr_in,
    input  wire logic [NUM_CH-1:0][31:0]       dst_addr_in,
    input  wire logic [NUM_CH-1:0]             indirect_in,
    input  wire logic [NUM_CH-1:0]             on_change_in,
    io_mirror_sequencer_if.master              bus,
    output logic                               busy_out,
    output logic [ch_width(NUM_CH)-1:0]        ch_out,
    output logic                               pass_done_out
);
    localparam int                 c_ch_w    = ch_width(NUM_CH);
    localparam logic [c_ch_w-1:0]  c_last_ch = c_ch_w'(NUM_CH - 1);

    seq_state_e                      r_state, w_state;
    logic [c_ch_w-1:0]               r_ch, w_ch;
    logic [31:0]                     r_addr, w_addr;
    logic [31:0]                     r_wr_data, w_wr_data;
    logic                            r_we, w_we;
    logic                            r_busy, w_busy;
    logic                            r_pass_done, w_pass_done;
    logic [DATA_W-1:0]               r_data, w_data;
    logic                            r_ind, w_ind;
    logic                            r_onchg, w_onchg;
    logic [31:0]                     r_dst, w_dst;
    logic [NUM_CH-1:0][DATA_W-1:0]   r_last, w_last;
    logic [NUM_CH-1:0]               r_valid, w_valid;
    logic                            w_lat_start;
    logic                            w_lat_done;
    logic                            w_skip;

    io_mirror_lat_cnt #(
        .RD_LATENCY (RD_LATENCY)
    ) u_lat_cnt (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start_in (w_lat_start),
        .done_out (w_lat_done)
    );

    assign w_skip = r_onchg && r_valid[r_ch] && (r_last[r_ch] == r_data);
    assign w_busy = (w_state != ST_IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_pass_done <= 1'b0;
            r_data      <= '0;
            r_ind       <= 1'b0;
            r_onchg     <= 1'b0;
            r_dst       <= '0;
            r_last      <= '0;
            r_valid     <= '0;
        end else begin
            r_state     <= w_state;
            r_ch        <= w_ch;
            r_addr      <= w_addr;
            r_wr_data   <= w_wr_data;
            r_we        <= w_we;
            r_busy      <= w_busy;
            r_pass_done <= w_pass_done;
            r_data      <= w_data;
            r_ind       <= w_ind;
            r_onchg     <= w_onchg;
            r_dst       <= w_dst;
            r_last      <= w_last;
            r_valid     <= w_valid;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_ch        = r_ch;
        w_addr      = r_addr;
        w_wr_data   = '0;
        w_we        = 1'b0;
        w_pass_done = 1'b0;
        w_data      = r_data;
        w_ind       = r_ind;
        w_onchg     = r_onchg;
        w_dst       = r_dst;
        w_last      = r_last;
        w_valid     = r_valid;
        w_lat_start = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable_in) begin
                    w_state = ST_SRC_ADDR;
                end
            end
            ST_SRC_ADDR: begin
                w_addr      = src_addr_in[r_ch];
                w_ind       = indirect_in[r_ch];
                w_onchg     = on_change_in[r_ch];
                w_dst       = dst_addr_in[r_ch];
                w_lat_start = 1'b1;
                w_state     = ST_SRC_WAIT;
            end
            ST_SRC_WAIT: begin
                if (w_lat_done) begin
                    w_data  = bus.rd_data_in[DATA_W-1:0];
                    w_state = r_ind ? ST_IND_ADDR : ST_WRITE;
                end
            end
            ST_IND_ADDR: begin
                w_addr      = 32'(r_data);
                w_lat_start = 1'b1;
                w_state     = ST_IND_WAIT;
            end
            ST_IND_WAIT: begin
                if (w_lat_done) begin
                    w_data  = bus.rd_data_in[DATA_W-1:0];
                    w_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!w_skip) begin
                    w_addr        = r_dst;
                    w_wr_data     = 32'(r_data);
                    w_we          = 1'b1;
                    w_last[r_ch]  = r_data;
                    w_valid[r_ch] = 1'b1;
                end
                w_state = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_ch == c_last_ch) begin
                    w_pass_done = 1'b1;
                end
                // On disable the index is kept so a later enable resumes at this channel.
                if (enable_in) begin
                    w_ch    = (r_ch == c_last_ch) ? '0 : r_ch + 1'b1;
                    w_state = ST_SRC_ADDR;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign bus.addr_out    = r_addr;
    assign bus.wr_data_out = r_wr_data;
    assign bus.we_out      = r_we;
    assign busy_out        = r_busy;
    assign ch_out          = r_ch;
    assign pass_done_out   = r_pass_done;
endmodule
`default_nettype wire

// File: tb/tb_io_mirror_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_mirror_sequencer
//  Brief    : Directed self-checking bench; DUT A (1 ch, lat 1), DUT B (3 ch, lat 3)
//  Revision : 1.0
// ============================================================================
module tb_io_mirror_sequencer;
    import memory_controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- DUT A: NUM_CH=1, RD_LATENCY=1 ----------------
    logic              rst_a, en_a;
    logic [0:0][31:0]  src_a, dst_a;
    logic [0:0]        ind_a, oc_a;
    logic [31:0]       sw_a;
    logic              a_busy, a_pd;
    logic [0:0]        a_ch;
    io_mirror_sequencer_if a_if ();

    assign src_a = SWITCH_BASE_ADDR;
    assign dst_a = LED_BASE_ADDR;
    always_comb begin
        a_if.rd_data_in = 32'h0;
        if (a_if.addr_out == SWITCH_BASE_ADDR) a_if.rd_data_in = sw_a;
        else if (a_if.addr_out == 32'h0000_0040) a_if.rd_data_in = 32'hDEAD_BEEF;
    end

    io_mirror_sequencer #(.NUM_CH(1), .DATA_W(16), .RD_LATENCY(1)) u_dut_a (
        .clk_in(clk), .rst_in(rst_a), .enable_in(en_a),
        .src_addr_in(src_a), .dst_addr_in(dst_a),
        .indirect_in(ind_a), .on_change_in(oc_a),
        .bus(a_if.master),
        .busy_out(a_busy), .ch_out(a_ch), .pass_done_out(a_pd)
    );

    // ---------------- DUT B: NUM_CH=3, RD_LATENCY=3 ----------------
    logic              rst_b, en_b;
    logic [2:0][31:0]  src_b, dst_b;
    logic [2:0]        ind_b, oc_b;
    logic              b_busy, b_pd;
    logic [1:0]        b_ch;
    logic [31:0]       b_p0, b_p1;
    logic              b_ch_bad = 1'b0;
    io_mirror_sequencer_if b_if ();

    assign src_b = {32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
    assign dst_b = {32'h0000_0208, 32'h0000_0204, 32'h0000_0200};
    assign ind_b = 3'b000;
    assign oc_b  = 3'b000;

    function automatic logic [31:0] mem_b(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'hAB00_0011;
            32'h0000_0104: return 32'hCD00_0022;
            32'h0000_0108: return 32'hEF00_0033;
            default:       return 32'h0;
        endcase
    endfunction

    // Two register stages plus the sampling edge give three cycles of read latency.
    always @(posedge clk) begin
        b_p0 <= mem_b(b_if.addr_out);
        b_p1 <= b_p0;
    end
    assign b_if.rd_data_in = b_p1;

    io_mirror_sequencer #(.NUM_CH(3), .DATA_W(16), .RD_LATENCY(3)) u_dut_b (
        .clk_in(clk), .rst_in(rst_b), .enable_in(en_b),
        .src_addr_in(src_b), .dst_addr_in(dst_b),
        .indirect_in(ind_b), .on_change_in(oc_b),
        .bus(b_if.master),
        .busy_out(b_busy), .ch_out(b_ch), .pass_done_out(b_pd)
    );

    // ---------------- monitors ----------------
    logic [31:0] a_addr_q[$];
    logic [31:0] a_prev = 32'h0;
    always @(posedge clk) begin
        #1;
        if (a_if.addr_out != a_prev) a_addr_q.push_back(a_if.addr_out);
        a_prev = a_if.addr_out;
        if (b_ch == 2'd3) b_ch_bad = 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_we(input bit sel_b, input string tag, output int t);
        t = -1;
        for (int k = 0; k < 64 && t < 0; k++) begin
            @(negedge clk);
            if ((sel_b ? b_if.we_out : a_if.we_out) === 1'b1) t = cyc;
        end
        if (t < 0) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle_a(input string tag);
        int k;
        k = 0;
        while (a_busy !== 1'b0 && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (k >= 64) check_val({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_a(input int n, output int we_n, output int pd_n, output logic [31:0] wd);
        we_n = 0; pd_n = 0; wd = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (a_if.we_out === 1'b1) begin
                we_n++;
                wd = a_if.wr_data_out;
            end
            if (a_pd === 1'b1) pd_n++;
        end
    endtask

    // ---------------- stimulus ----------------
    int          ts, t0, t1, tprev, we_n, pd_n;
    logic [31:0] wd;
    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];
    logic [1:0]  exp_ch   [4];

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        ind_a = 1'b0; oc_a = 1'b0; sw_a = 32'hFFFF_1234;
        step(2);

        check_val("rst_a_addr",  a_if.addr_out, 32'h0);
        check_val("rst_a_wdata", a_if.wr_data_out, 32'h0);
        check_val("rst_a_we",    32'(a_if.we_out), 32'h0);
        check_val("rst_a_busy",  32'(a_busy), 32'h0);
        check_val("rst_a_pd",    32'(a_pd), 32'h0);
        check_val("rst_b_ch",    32'(b_ch), 32'h0);
        check_val("rst_b_busy",  32'(b_busy), 32'h0);

        // Direct mirror, one channel.
        rst_a = 1'b0; en_a = 1'b1; ts = cyc;
        wait_we(1'b0, "t1_w0", t0);
        check_val("t1_first_lat", 32'(t0 - ts), 32'd4);
        check_val("t1_addr",  a_if.addr_out, LED_BASE_ADDR);
        check_val("t1_data",  a_if.wr_data_out, 32'h0000_1234);
        check_val("t1_busy",  32'(a_busy), 32'd1);
        step(1);
        check_val("t1_pd",    32'(a_pd), 32'd1);
        check_val("t1_we_pulse", 32'(a_if.we_out), 32'd0);
        wait_we(1'b0, "t1_w1", t1);
        check_val("t1_period", 32'(t1 - t0), 32'd4);
        check_val("t1_data2", a_if.wr_data_out, 32'h0000_1234);

        // Indirect read through the switch word.
        en_a = 1'b0;
        wait_idle_a("t2");
        ind_a = 1'b1; sw_a = 32'h0000_0040;
        a_addr_q.delete();
        en_a = 1'b1; ts = cyc;
        wait_we(1'b0, "t2_w0", t0);
        check_val("t2_first_lat", 32'(t0 - ts), 32'd6);
        check_val("t2_data", a_if.wr_data_out, 32'h0000_BEEF);
        check_val("t2_addr_cnt", 32'(a_addr_q.size()), 32'd3);
        check_val("t2_addr0", a_addr_q[0], SWITCH_BASE_ADDR);
        check_val("t2_addr1", a_addr_q[1], 32'h0000_0040);
        check_val("t2_addr2", a_addr_q[2], LED_BASE_ADDR);
        wait_we(1'b0, "t2_w1", t1);
        check_val("t2_period", 32'(t1 - t0), 32'd6);

        // Write-on-change suppression.
        en_a = 1'b0; ind_a = 1'b0; oc_a = 1'b1; sw_a = 32'h0000_00AA; rst_a = 1'b1;
        step(1);
        rst_a = 1'b0; en_a = 1'b1;
        run_a(24, we_n, pd_n, wd);
        check_val("t3_aa_writes", 32'(we_n), 32'd1);
        check_val("t3_aa_data",   wd, 32'h0000_00AA);
        check_val("t3_aa_passes", 32'(pd_n), 32'd5);
        sw_a = 32'h0000_00AB;
        run_a(24, we_n, pd_n, wd);
        check_val("t3_ab_writes", 32'(we_n), 32'd1);
        check_val("t3_ab_data",   wd, 32'h0000_00AB);
        check_val("t3_ab_passes", 32'(pd_n), 32'd6);
        sw_a = 32'h5555_00AB;
        run_a(12, we_n, pd_n, wd);
        check_val("t3_upper_ignored", 32'(we_n), 32'd0);

        // Reset in the cycle where a write is pending.
        en_a = 1'b0;
        wait_idle_a("t6");
        sw_a = 32'h0000_00CC; en_a = 1'b1;
        step(3);
        check_val("t6_pre_we", 32'(a_if.we_out), 32'd0);
        rst_a = 1'b1;
        step(1);
        check_val("t6_we",    32'(a_if.we_out), 32'd0);
        check_val("t6_addr",  a_if.addr_out, 32'h0);
        check_val("t6_wdata", a_if.wr_data_out, 32'h0);
        check_val("t6_busy",  32'(a_busy), 32'd0);
        check_val("t6_pd",    32'(a_pd), 32'd0);
        sw_a = 32'h0000_00AB; rst_a = 1'b0;
        run_a(20, we_n, pd_n, wd);
        check_val("t6_rewrite", 32'(we_n), 32'd1);
        check_val("t6_rewrite_data", wd, 32'h0000_00AB);

        // Three channels, latency 3: order and cadence.
        exp_addr = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0208, 32'h0000_0200};
        exp_data = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0011};
        exp_ch   = '{2'd0, 2'd1, 2'd2, 2'd0};
        rst_b = 1'b0; en_b = 1'b1; tprev = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_we(1'b1, "t4_w", t0);
            check_val($sformatf("t4_gap%0d", i),  32'(t0 - tprev), 32'd6);
            check_val($sformatf("t4_addr%0d", i), b_if.addr_out, exp_addr[i]);
            check_val($sformatf("t4_data%0d", i), b_if.wr_data_out, exp_data[i]);
            check_val($sformatf("t4_ch%0d", i),   32'(b_ch), 32'(exp_ch[i]));
            tprev = t0;
            if (i == 2) begin
                step(1);
                check_val("t4_pass_done", 32'(b_pd), 32'd1);
            end
        end
        check_val("t4_ch_range", 32'(b_ch_bad), 32'd0);

        // Enable dropped during ch1's source wait.
        rst_b = 1'b1; en_b = 1'b0;
        step(1);
        rst_b = 1'b0; en_b = 1'b1;
        wait_we(1'b1, "t5_w0", t0);
        check_val("t5_ch0", 32'(b_ch), 32'd0);
        step(2);
        en_b = 1'b0;
        wait_we(1'b1, "t5_w1", t1);
        check_val("t5_ch1_addr", b_if.addr_out, 32'h0000_0204);
        check_val("t5_ch1_data", b_if.wr_data_out, 32'h0000_0022);
        step(1);
        check_val("t5_idle_busy", 32'(b_busy), 32'd0);
        check_val("t5_idle_pd",   32'(b_pd), 32'd0);
        step(3);
        check_val("t5_still_idle", 32'(b_busy), 32'd0);
        en_b = 1'b1;
        step(2);
        check_val("t5_resume_addr", b_if.addr_out, 32'h0000_0104);
        wait_we(1'b1, "t5_w2", t1);
        check_val("t5_resume_dst", b_if.addr_out, 32'h0000_0204);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
